// File: rtl/micro_sequencer_pkg.sv
// Shared micro-sequencer constants and branch-type encodings, also used by the ROM encoder.
// MICRO_CALL_EN enables the micro-call stack sized by STACK_DEPTH.
package micro_sequencer_pkg;

   localparam int UA_WIDTH    = 6;
   localparam int SEL_WIDTH   = 3;
   localparam int STACK_DEPTH = 4;

   localparam logic [UA_WIDTH-1:0] FETCH_ADDR   = 6'd0;
   localparam logic [UA_WIDTH-1:0] ILLEGAL_ADDR = 6'd63;

   typedef enum logic [SEL_WIDTH-1:0] {
      UBR_NEXT     = 3'd0,
      UBR_SPIN     = 3'd1,
      UBR_JUMP     = 3'd2,
      UBR_BEQZ     = 3'd3,
      UBR_BNEZ     = 3'd4,
      UBR_DISPATCH = 3'd5,
      UBR_FETCH    = 3'd6,
      UBR_CALLRET  = 3'd7
   } ubr_e;

endpackage

// File: rtl/micro_sequencer_mux.sv
// Generic 8-way selector used for the micro-sequencer next-address choice.
// Independent of MICRO_CALL_EN.
module mux_8x1 #(
   parameter int SEL_WIDTH  = 3,
   parameter int DATA_WIDTH = 6
) (
   input  logic [SEL_WIDTH-1:0]  sel,
   input  logic [DATA_WIDTH-1:0] d0,
   input  logic [DATA_WIDTH-1:0] d1,
   input  logic [DATA_WIDTH-1:0] d2,
   input  logic [DATA_WIDTH-1:0] d3,
   input  logic [DATA_WIDTH-1:0] d4,
   input  logic [DATA_WIDTH-1:0] d5,
   input  logic [DATA_WIDTH-1:0] d6,
   input  logic [DATA_WIDTH-1:0] d7,
   output logic [DATA_WIDTH-1:0] y
);

   always_comb begin
      y = d0;
      case (sel)
         3'd0: y = d0;
         3'd1: y = d1;
         3'd2: y = d2;
         3'd3: y = d3;
         3'd4: y = d4;
         3'd5: y = d5;
         3'd6: y = d6;
         3'd7: y = d7;
         default: y = d0;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// Micro-PC register and next-address logic; the branch field of the current microinstruction picks the next uPC.
// Define MICRO_CALL_EN to turn ubr=7 into CALL/RET on a local micro-stack; otherwise ubr=7 behaves as FETCH.
module micro_sequencer
   import micro_sequencer_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [SEL_WIDTH-1:0] ubr,
   input  logic [UA_WIDTH-1:0]  utarget,
   input  logic                 zero,
   input  logic                 busy,
   input  logic [UA_WIDTH-1:0]  dispatch_addr,
   input  logic                 dispatch_valid,
   output logic [UA_WIDTH-1:0]  upc,
   output logic                 illegal,
   output logic                 ustack_err
);

   logic [UA_WIDTH-1:0] inc;
   logic [UA_WIDTH-1:0] spin_addr;
   logic [UA_WIDTH-1:0] beqz_addr;
   logic [UA_WIDTH-1:0] bnez_addr;
   logic [UA_WIDTH-1:0] disp_addr;
   logic [UA_WIDTH-1:0] callret_addr;
   logic [UA_WIDTH-1:0] next_upc;

   assign inc       = upc + UA_WIDTH'(1);
   assign spin_addr = busy ? upc : inc;
   assign beqz_addr = zero ? utarget : inc;
   assign bnez_addr = zero ? inc : utarget;
   assign disp_addr = dispatch_valid ? dispatch_addr : ILLEGAL_ADDR;

`ifdef MICRO_CALL_EN
   localparam int PTR_W = $clog2(STACK_DEPTH);

   logic [UA_WIDTH-1:0] ustack [STACK_DEPTH];
   logic [PTR_W:0]      sp;
   logic [PTR_W-1:0]    top_idx;
   logic                is_call;
   logic                is_ret;
   logic                stack_full;
   logic                stack_empty;

   // An all-ones target marks a return; any other target is a call destination.
   assign is_call     = (ubr == UBR_CALLRET) && (utarget != '1);
   assign is_ret      = (ubr == UBR_CALLRET) && (utarget == '1);
   assign stack_full  = (sp == (PTR_W+1)'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign top_idx     = PTR_W'(sp - (PTR_W+1)'(1));

   assign callret_addr = is_ret ? (stack_empty ? FETCH_ADDR : ustack[top_idx]) : utarget;

   always_ff @(posedge clk) begin
      if (rst) begin
         sp         <= '0;
         ustack_err <= 1'b0;
      end else begin
         ustack_err <= (is_call && stack_full) || (is_ret && stack_empty);
         if (is_call && !stack_full)
            sp <= sp + (PTR_W+1)'(1);
         else if (is_ret && !stack_empty)
            sp <= sp - (PTR_W+1)'(1);
      end
   end

   // Entry storage needs no reset; the pointer alone defines which entries are live.
   always_ff @(posedge clk) begin
      if (!rst && is_call && !stack_full)
         ustack[sp[PTR_W-1:0]] <= inc;
   end
`else
   assign callret_addr = FETCH_ADDR;
   assign ustack_err   = 1'b0;
`endif

   mux_8x1 #(
      .SEL_WIDTH  (SEL_WIDTH),
      .DATA_WIDTH (UA_WIDTH)
   ) u_next_mux (
      .sel (ubr),
      .d0  (inc),
      .d1  (spin_addr),
      .d2  (utarget),
      .d3  (beqz_addr),
      .d4  (bnez_addr),
      .d5  (disp_addr),
      .d6  (FETCH_ADDR),
      .d7  (callret_addr),
      .y   (next_upc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         upc     <= FETCH_ADDR;
         illegal <= 1'b0;
      end else begin
         upc     <= next_upc;
         illegal <= (ubr == UBR_DISPATCH) && !dispatch_valid;
      end
   end

endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus randomized traffic against a reference model.
// Covers the ubr=7 call/return stack when MICRO_CALL_EN is defined, FETCH behaviour otherwise.
module tb_micro_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] ubr = 3'd0;
   logic [5:0] utarget = 6'd0;
   logic       zero = 1'b0;
   logic       busy = 1'b0;
   logic [5:0] dispatch_addr = 6'd0;
   logic       dispatch_valid = 1'b0;
   logic [5:0] upc;
   logic       illegal;
   logic       ustack_err;

   int tests = 0;
   int fails = 0;

   logic [5:0] m_upc;
   logic       m_ill;
   logic       m_err;
   logic [5:0] m_stack[$];

   micro_sequencer dut (
      .clk            (clk),
      .rst            (rst),
      .ubr            (ubr),
      .utarget        (utarget),
      .zero           (zero),
      .busy           (busy),
      .dispatch_addr  (dispatch_addr),
      .dispatch_valid (dispatch_valid),
      .upc            (upc),
      .illegal        (illegal),
      .ustack_err     (ustack_err)
   );

   always #5 clk = ~clk;

   // Reference model: next micro-address from the branch rules with plain integer arithmetic.
   task automatic model_step(input logic r, input int b, input int t, input logic z,
                             input logic bz, input int da, input logic dv);
      int cur;
      int nxt;
      int inc;
      cur = int'(m_upc);
      inc = (cur + 1) % 64;
      nxt = inc;
      m_ill = 1'b0;
      m_err = 1'b0;
      if (r) begin
         nxt = 0;
         m_stack.delete();
      end else begin
         case (b)
            0: nxt = inc;
            1: nxt = bz ? cur : inc;
            2: nxt = t;
            3: nxt = z ? t : inc;
            4: nxt = z ? inc : t;
            5: begin
               if (dv) nxt = da;
               else begin
                  nxt = 63;
                  m_ill = 1'b1;
               end
            end
            6: nxt = 0;
            default: begin
`ifdef MICRO_CALL_EN
               if (t != 63) begin
                  if (m_stack.size() < 4) m_stack.push_back(6'(inc));
                  else m_err = 1'b1;
                  nxt = t;
               end else if (m_stack.size() == 0) begin
                  nxt = 0;
                  m_err = 1'b1;
               end else begin
                  nxt = int'(m_stack.pop_back());
               end
`else
               nxt = 0;
`endif
            end
         endcase
      end
      m_upc = 6'(nxt);
   endtask

   task automatic applyStimulus(input logic r, input int b, input int t, input logic z,
                                input logic bz, input int da, input logic dv);
      rst            = r;
      ubr            = 3'(b);
      utarget        = 6'(t);
      zero           = z;
      busy           = bz;
      dispatch_addr  = 6'(da);
      dispatch_valid = dv;
      model_step(r, b, t, z, bz, da, dv);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
         tests++;
         if (upc !== 6'd0 || illegal !== 1'b0 || ustack_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset: upc=%0d illegal=%b err=%b, want upc=0 illegal=0 err=0",
                     upc, illegal, ustack_err);
         end
      end
      for (int i = 1; i <= 5; i++) begin
         applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
         tests++;
         if (upc !== 6'(i) || illegal !== 1'b0) begin
            fails++;
            $display("[TB] FAIL next_%0d: upc=%0d illegal=%b, want upc=%0d illegal=0", i, upc, illegal, i);
         end
      end
   endtask

   task automatic test_spin;
      applyStimulus(1'b0, 2, 10, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tests++;
         if (upc !== 6'd10) begin
            fails++;
            $display("[TB] FAIL spin_hold_%0d: upc=%0d, want 10", i, upc);
         end
         if (i < 3) applyStimulus(1'b0, 1, 0, 1'b0, 1'b1, 0, 1'b0);
      end
      applyStimulus(1'b0, 1, 0, 1'b0, 1'b0, 0, 1'b0);
      tests++;
      if (upc !== 6'd11) begin
         fails++;
         $display("[TB] FAIL spin_release: upc=%0d, want 11", upc);
      end
      applyStimulus(1'b0, 1, 0, 1'b0, 1'b1, 0, 1'b0);
      applyStimulus(1'b1, 1, 0, 1'b0, 1'b1, 0, 1'b0);
      tests++;
      if (upc !== 6'd0) begin
         fails++;
         $display("[TB] FAIL spin_reset: upc=%0d, want 0", upc);
      end
   endtask

   task automatic test_branch;
      int b;
      int z;
      int want;
      for (int i = 0; i < 4; i++) begin
         b = (i < 2) ? 3 : 4;
         z = i % 2;
         want = ((b == 3) == (z == 1)) ? 40 : 21;
         applyStimulus(1'b0, 2, 20, 1'b0, 1'b0, 0, 1'b0);
         applyStimulus(1'b0, b, 40, z[0], 1'b0, 0, 1'b0);
         tests++;
         if (upc !== 6'(want)) begin
            fails++;
            $display("[TB] FAIL branch_ubr%0d_zero%0d: upc=%0d, want %0d", b, z, upc, want);
         end
      end
      applyStimulus(1'b0, 2, 63, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      tests++;
      if (upc !== 6'd0) begin
         fails++;
         $display("[TB] FAIL wrap: upc=%0d, want 0", upc);
      end
   endtask

   task automatic test_dispatch;
      applyStimulus(1'b0, 5, 0, 1'b0, 1'b0, 17, 1'b1);
      tests++;
      if (upc !== 6'd17 || illegal !== 1'b0) begin
         fails++;
         $display("[TB] FAIL dispatch_valid: upc=%0d illegal=%b, want 17 0", upc, illegal);
      end
      applyStimulus(1'b0, 5, 0, 1'b0, 1'b0, 17, 1'b0);
      tests++;
      if (upc !== 6'd63 || illegal !== 1'b1) begin
         fails++;
         $display("[TB] FAIL dispatch_illegal: upc=%0d illegal=%b, want 63 1", upc, illegal);
      end
      applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      tests++;
      if (upc !== 6'd0 || illegal !== 1'b0) begin
         fails++;
         $display("[TB] FAIL illegal_pulse_end: upc=%0d illegal=%b, want 0 0", upc, illegal);
      end
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1'b0, 5, 0, 1'b0, 1'b0, 9, 1'b0);
         tests++;
         if (illegal !== 1'b1) begin
            fails++;
            $display("[TB] FAIL illegal_repeat_%0d: illegal=%b, want 1", i, illegal);
         end
      end
   endtask

`ifdef MICRO_CALL_EN
   task automatic test_callret;
      int want [4] = '{30, 45, 31, 6};
      int tgt  [4] = '{30, 45, 63, 63};
      applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 2, 5, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 7, tgt[i], 1'b0, 1'b0, 0, 1'b0);
         tests++;
         if (upc !== 6'(want[i]) || ustack_err !== 1'b0) begin
            fails++;
            $display("[TB] FAIL callret_%0d: upc=%0d err=%b, want %0d 0", i, upc, ustack_err, want[i]);
         end
      end
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 7, 8 + i, 1'b0, 1'b0, 0, 1'b0);
         tests++;
         if (upc !== 6'(8 + i) || ustack_err !== (i == 4)) begin
            fails++;
            $display("[TB] FAIL overflow_%0d: upc=%0d err=%b, want %0d %b", i, upc, ustack_err, 8 + i, i == 4);
         end
      end
      applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 7, 63, 1'b0, 1'b0, 0, 1'b0);
      tests++;
      if (upc !== 6'd0 || ustack_err !== 1'b1) begin
         fails++;
         $display("[TB] FAIL underflow: upc=%0d err=%b, want 0 1", upc, ustack_err);
      end
   endtask
`else
   task automatic test_no_call;
      applyStimulus(1'b0, 2, 12, 1'b0, 1'b0, 0, 1'b0);
      applyStimulus(1'b0, 7, 30, 1'b0, 1'b0, 0, 1'b0);
      tests++;
      if (upc !== 6'd0 || ustack_err !== 1'b0) begin
         fails++;
         $display("[TB] FAIL no_call: upc=%0d err=%b, want 0 0", upc, ustack_err);
      end
   endtask
`endif

   task automatic test_random;
      int t;
      applyStimulus(1'b1, 0, 0, 1'b0, 1'b0, 0, 1'b0);
      for (int i = 0; i < 400; i++) begin
         t = ($urandom_range(3) == 0) ? 63 : int'($urandom_range(63));
         applyStimulus(($urandom_range(49) == 0), int'($urandom_range(7)), t,
                       1'($urandom), 1'($urandom), int'($urandom_range(63)), 1'($urandom));
         tests++;
         if (upc !== m_upc || illegal !== m_ill || ustack_err !== m_err) begin
            fails++;
            $display("[TB] FAIL random_%0d: upc=%0d illegal=%b err=%b, want %0d %b %b",
                     i, upc, illegal, ustack_err, m_upc, m_ill, m_err);
         end
      end
   endtask

   initial begin
      m_upc = 6'd0;
      m_ill = 1'b0;
      m_err = 1'b0;
      test_reset;
      test_spin;
      test_branch;
      test_dispatch;
`ifdef MICRO_CALL_EN
      test_callret;
`else
      test_no_call;
`endif
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Micro-PC (uPC) register and next-address logic for the microprogrammed bus-based RISC-V controller.
- Each cycle it drives an 8-way next-address select (the existing 8x1 mux with 3-bit select and 6-bit data) from the current microinstruction's branch field.
- It registers the selected address as the new uPC, which addresses the microcode ROM.
- Sits between the microcode ROM output (branch type, target field) and the ROM address input.

Parameters:
- UA_WIDTH, 6, micro-address width; must equal the 8x1 mux data width.
- SEL_WIDTH, 3, branch-type field width.
- FETCH_ADDR, 6'd0, microroutine entry for instruction fetch.
- ILLEGAL_ADDR, 6'd63, microroutine entry for illegal-opcode handling.
- STACK_DEPTH, 4, micro-call stack entries; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ubr  in  SEL_WIDTH  branch type of the current microinstruction.
- utarget  in  UA_WIDTH  jump/branch target field of the current microinstruction.
- zero  in  1  ALU zero flag, valid in the same cycle.
- busy  in  1  memory busy, for wait-state spin.
- dispatch_addr  in  UA_WIDTH  entry address from the opcode decode ROM.
- dispatch_valid  in  1  opcode is legal.
- upc  out  UA_WIDTH  registered micro-PC; drives the ROM address.
- illegal  out  1  one-cycle pulse when dispatching an illegal opcode.
- ustack_err  out  1  one-cycle pulse on micro-stack overflow or underflow; tied 0 when the feature is absent.

Behaviour:
- One clock, clk. Reset is synchronous and active-high (rst).
- On rst: upc=FETCH_ADDR, illegal=0, ustack_err=0, stack pointer=0. rst has priority over every other input, including mid-spin and mid-call.
- upc updates every rising edge to next_upc. ROM data for upc is combinational (same cycle), so branch decisions have zero added latency: ubr/utarget are sampled in the cycle upc points at them.
- inc = upc+1, modulo 2^UA_WIDTH (63 wraps to 0, no flag).
- next_upc by ubr:
  - 0 NEXT: inc.
  - 1 SPIN: upc if busy=1, else inc.
  - 2 JUMP: utarget.
  - 3 BEQZ: utarget if zero=1, else inc.
  - 4 BNEZ: utarget if zero=0, else inc.
  - 5 DISPATCH: dispatch_addr if dispatch_valid=1. Otherwise ILLEGAL_ADDR, with illegal=1 for the following cycle only.
  - 6 FETCH: FETCH_ADDR.
  - 7 CALLRET: see Optional Feature. Without the feature it behaves as FETCH.
- Outputs illegal and ustack_err are registered: asserted in the cycle after the triggering cycle, deasserted in the next cycle unless retriggered.
- SPIN with busy held high holds upc indefinitely; no timeout.
- Consecutive DISPATCHes with dispatch_valid=0 produce one pulse per dispatch.

Optional Feature:
- Macro: MICRO_CALL_EN.
- When defined, ubr=7 uses a LIFO of STACK_DEPTH UA_WIDTH-bit entries:
  - If utarget != all-ones: CALL. Push inc, next_upc=utarget.
  - If utarget == all-ones: RET. Pop, next_upc=popped value.
- CALL when full: next_upc=utarget, the push is dropped, and the stack is unchanged; ustack_err pulses.
- RET when empty: next_upc=FETCH_ADDR; ustack_err pulses.
- When not defined: no stack storage exists, ubr=7 acts as FETCH, and ustack_err is constant 0.

Decomposition:
- Shared package/include holds:
  - The UBR_* encodings: NEXT=0, SPIN=1, JUMP=2, BEQZ=3, BNEZ=4, DISPATCH=5, FETCH=6, CALLRET=7.
  - UA_WIDTH, FETCH_ADDR, ILLEGAL_ADDR.
- The ROM encoder uses the same constants.
- Sub-module: instantiate the existing mux_8x1 (SEL_WIDTH=3, DATA_WIDTH=UA_WIDTH) for the final selection.
  - Condition logic pre-computes the BEQZ/BNEZ/SPIN/DISPATCH/CALLRET inputs.
  - ubr drives the mux select.
- The micro-stack is local logic in this block, not a separate module.

Test Plan:
1. Reset and NEXT: assert rst 2 cycles, then ubr=NEXT for 5 cycles. Required: upc = 0,0,1,2,3,4,5; illegal=0.
2. SPIN: at upc=10, ubr=SPIN with busy=1 for 3 cycles, then 0. Required: upc=10 for 4 samples, then 11. Also assert rst during a spin: upc=0 next cycle.
3. Branches: upc=20, utarget=40, ubr=BEQZ. zero=1 gives upc=40; zero=0 gives upc=21. Repeat with BNEZ and check the inverse. At upc=63 with NEXT: upc=0.
4. Dispatch: ubr=DISPATCH, dispatch_addr=17, valid=1 gives upc=17, illegal=0. With valid=0: upc=63, and illegal=1 for exactly one cycle.
5. Calls (MICRO_CALL_EN): nested CALLs from 5→30→45, then two RETs. Required: upc=30,45,31,6.
   - 5 CALLs with STACK_DEPTH=4: ustack_err pulses on the 5th.
   - RET on empty: upc=0, ustack_err pulses.
6. No-feature build: ubr=7 at upc=12 gives upc=0; ustack_err stays 0.
